// File: rtl/spi_master.sv
// Byte-wide SPI master (mode 0) for the two SD card slots, mapped as a 4-byte CPU window.
// Optional SPI_AUTOXFER_EN: a DATA read while idle also starts a 0xFF transfer.
module spi_master #(
   parameter int unsigned DIV_RESET = 59
) (
   input  logic       MHZ48,
   input  logic       nRES,
   input  logic       nSEL,
   input  logic       RW,
   input  logic [1:0] A,
   input  logic [7:0] DIN,
   output logic [7:0] DOUT,
   output logic       SCLK,
   output logic       MOSI,
   input  logic       MISO,
   output logic       nSD0,
   output logic       nSD1
);

   typedef enum logic [1:0] {
      Idle,
      Low,
      High
   } stateT;

   stateT      state;
   stateT      stateNext;

   logic       nSelQ;
   logic [1:0] addrLat;
   logic       rwLat;
   logic [7:0] dinLat;
   logic       commit;

   logic [7:0] txShift;
   logic [7:0] rxShift;
   logic [7:0] dataReg;
   logic [7:0] divReg;
   logic [7:0] halfCnt;
   logic [2:0] bitCnt;
   logic       ovr;
   logic       sclkReg;
   logic       mosiReg;
   logic       nSd0Reg;
   logic       nSd1Reg;
   logic       busy;

   logic       dataWrite;
   logic       dataRead;
   logic       startXfer;
   logic       dropXfer;
   logic       riseEdge;
   logic       fallShift;
   logic       fallLast;
   logic [7:0] startByte;

   // An access commits on the trailing edge of nSEL, using the bus values latched while selected.
   assign commit    = !nSelQ && nSEL;
   assign busy      = (state != Idle);
   assign dataWrite = commit && (addrLat == 2'd0) && !rwLat;
`ifdef SPI_AUTOXFER_EN
   assign dataRead  = commit && (addrLat == 2'd0) && rwLat;
`else
   assign dataRead  = 1'b0;
`endif

   // Next-state and strobe decode; a start request while busy becomes an overrun instead.
   always_comb begin
      stateNext = state;
      startXfer = 1'b0;
      dropXfer  = 1'b0;
      riseEdge  = 1'b0;
      fallShift = 1'b0;
      fallLast  = 1'b0;
      startByte = dataWrite ? dinLat : 8'hFF;
      if (dataWrite || dataRead) begin
         if (busy) begin
            dropXfer = 1'b1;
         end else begin
            startXfer = 1'b1;
         end
      end
      case (state)
         Idle: begin
            if (startXfer) begin
               stateNext = Low;
            end
         end
         Low: begin
            if (halfCnt == 8'd0) begin
               stateNext = High;
               riseEdge  = 1'b1;
            end
         end
         High: begin
            if (halfCnt == 8'd0) begin
               if (bitCnt == 3'd7) begin
                  stateNext = Idle;
                  fallLast  = 1'b1;
               end else begin
                  stateNext = Low;
                  fallShift = 1'b1;
               end
            end
         end
         default: stateNext = Idle;
      endcase
   end

   // State, bus latch, shift datapath and CPU-visible registers.
   always_ff @(posedge MHZ48) begin
      if (!nRES) begin
         state   <= Idle;
         nSelQ   <= 1'b1;
         addrLat <= 2'd0;
         rwLat   <= 1'b1;
         dinLat  <= 8'h00;
         txShift <= 8'hFF;
         rxShift <= 8'h00;
         dataReg <= 8'hFF;
         divReg  <= DIV_RESET[7:0];
         halfCnt <= 8'd0;
         bitCnt  <= 3'd0;
         ovr     <= 1'b0;
         sclkReg <= 1'b0;
         mosiReg <= 1'b1;
         nSd0Reg <= 1'b1;
         nSd1Reg <= 1'b1;
      end else begin
         state <= stateNext;
         nSelQ <= nSEL;
         if (!nSEL) begin
            addrLat <= A;
            rwLat   <= RW;
            dinLat  <= DIN;
         end
         if (startXfer) begin
            txShift <= startByte;
            mosiReg <= startByte[7];
            halfCnt <= divReg;
            bitCnt  <= 3'd0;
         end else if (riseEdge) begin
            sclkReg <= 1'b1;
            rxShift <= {rxShift[6:0], MISO};
            halfCnt <= divReg;
         end else if (fallShift) begin
            sclkReg <= 1'b0;
            txShift <= {txShift[6:0], 1'b0};
            mosiReg <= txShift[6];
            bitCnt  <= bitCnt + 3'd1;
            halfCnt <= divReg;
         end else if (fallLast) begin
            sclkReg <= 1'b0;
            mosiReg <= 1'b1;
            dataReg <= rxShift;
         end else if (busy) begin
            halfCnt <= halfCnt - 8'd1;
         end
         if (dropXfer) begin
            ovr <= 1'b1;
         end else if (commit && rwLat && (addrLat == 2'd1)) begin
            ovr <= 1'b0;
         end
         if (commit && !rwLat) begin
            case (addrLat)
               2'd1: begin
                  nSd0Reg <= dinLat[0];
                  nSd1Reg <= dinLat[1];
               end
               2'd2: divReg <= dinLat;
               default: ;
            endcase
         end
      end
   end

   // Zero-latency read mux on the live address.
   always_comb begin
      case (A)
         2'd0:    DOUT = dataReg;
         2'd1:    DOUT = {busy, ovr, 4'b0000, nSd1Reg, nSd0Reg};
         2'd2:    DOUT = divReg;
         default: DOUT = 8'hFF;
      endcase
   end

   assign SCLK = sclkReg;
   assign MOSI = mosiReg;
   assign nSD0 = nSd0Reg;
   assign nSD1 = nSd1Reg;

endmodule
